// File: rtl/memoria_dp.sv
// Dual-port register-file memory with per-entry written bits, read-first
// same-address behaviour, port-A priority on write collisions and a collision counter.
module memoria_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  uninit_a,
  output logic                  uninit_b,
  output logic                  collision,
  output logic [7:0]            col_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      wr_q, wr_d;
  logic [DATA_WIDTH-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
  logic                  valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic                  uninit_a_q, uninit_a_d, uninit_b_q, uninit_b_d;
  logic                  collision_q, collision_d;
  logic [7:0]            col_count_q, col_count_d;

  logic rd_a_s, rd_b_s, wr_a_s, wr_b_s, col_s;

  assign rd_a_s = req_a & ~we_a;
  assign rd_b_s = req_b & ~we_b;
  assign wr_a_s = req_a & we_a;
  assign wr_b_s = req_b & we_b;
  assign col_s  = wr_a_s & wr_b_s & (addr_a == addr_b);

  // Next-state: reads sample the pre-write contents; port A's write is applied last so it wins.
  always_comb begin
    mem_d       = mem_q;
    wr_d        = wr_q;
    q_a_d       = q_a_q;
    q_b_d       = q_b_q;
    valid_a_d   = rd_a_s;
    valid_b_d   = rd_b_s;
    uninit_a_d  = 1'b0;
    uninit_b_d  = 1'b0;
    collision_d = col_s;
    col_count_d = col_count_q;

    if (rd_a_s) begin
      q_a_d      = mem_q[addr_a];
      uninit_a_d = ~wr_q[addr_a];
    end else begin
      q_a_d      = q_a_q;
    end

    if (rd_b_s) begin
      q_b_d      = mem_q[addr_b];
      uninit_b_d = ~wr_q[addr_b];
    end else begin
      q_b_d      = q_b_q;
    end

    if (wr_b_s) begin
      mem_d[addr_b] = data_b;
      wr_d[addr_b]  = 1'b1;
    end else begin
      wr_d = wr_d;
    end

    if (wr_a_s) begin
      mem_d[addr_a] = data_a;
      wr_d[addr_a]  = 1'b1;
    end else begin
      wr_d = wr_d;
    end

    if (col_s && (col_count_q != 8'hFF)) begin
      col_count_d = col_count_q + 8'd1;
    end else begin
      col_count_d = col_count_q;
    end
  end

  // State register with synchronous active-low reset clearing memory, flags and outputs.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_q        <= {DEPTH{1'b0}};
      q_a_q       <= {DATA_WIDTH{1'b0}};
      q_b_q       <= {DATA_WIDTH{1'b0}};
      valid_a_q   <= 1'b0;
      valid_b_q   <= 1'b0;
      uninit_a_q  <= 1'b0;
      uninit_b_q  <= 1'b0;
      collision_q <= 1'b0;
      col_count_q <= 8'd0;
    end else begin
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
      valid_a_q   <= valid_a_d;
      valid_b_q   <= valid_b_d;
      uninit_a_q  <= uninit_a_d;
      uninit_b_q  <= uninit_b_d;
      collision_q <= collision_d;
      col_count_q <= col_count_d;
    end
  end

  assign q_a       = q_a_q;
  assign q_b       = q_b_q;
  assign valid_a   = valid_a_q;
  assign valid_b   = valid_b_q;
  assign uninit_a  = uninit_a_q;
  assign uninit_b  = uninit_b_q;
  assign collision = collision_q;
  assign col_count = col_count_q;

endmodule

// File: tb/tb_memoria_dp.sv
// Scoreboard bench for memoria_dp: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_memoria_dp;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       req_a, we_a, req_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic [7:0] q_a, q_b, col_count;
  logic       valid_a, valid_b, uninit_a, uninit_b, collision;

  memoria_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset_L(reset_L),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
    .q_a(q_a), .q_b(q_b), .valid_a(valid_a), .valid_b(valid_b),
    .uninit_a(uninit_a), .uninit_b(uninit_b),
    .collision(collision), .col_count(col_count)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_mem [64];
  bit         m_wr  [64];
  logic [8:0] qa [$];
  logic [8:0] qb [$];
  bit         exp_col;
  int         exp_cnt;
  logic [7:0] last_qa, last_qb;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model updated right after the capturing edge.
  task automatic cyc(input bit rl,
                     input bit ra, input bit wa, input logic [5:0] aa, input logic [7:0] da,
                     input bit rb, input bit wb, input logic [5:0] ab, input logic [7:0] db);
    reset_L = rl;
    req_a = ra; we_a = wa; addr_a = aa; data_a = da;
    req_b = rb; we_b = wb; addr_b = ab; data_b = db;
    @(posedge clk);
    if (!rl) begin
      for (int i = 0; i < 64; i++) begin
        m_mem[i] = 8'h00;
        m_wr[i]  = 1'b0;
      end
      qa.delete();
      qb.delete();
      exp_col = 1'b0;
      exp_cnt = 0;
      last_qa = 8'h00;
      last_qb = 8'h00;
    end else begin
      if (ra && !wa) qa.push_back({~m_wr[aa], m_mem[aa]});
      if (rb && !wb) qb.push_back({~m_wr[ab], m_mem[ab]});
      exp_col = ra && wa && rb && wb && (aa == ab);
      if (exp_col && exp_cnt < 255) exp_cnt++;
      if (ra && wa) begin
        m_mem[aa] = da;
        m_wr[aa]  = 1'b1;
      end
      if (rb && wb && !(ra && wa && aa == ab)) begin
        m_mem[ab] = db;
        m_wr[ab]  = 1'b1;
      end
    end
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  // Monitor: pops expected reads whenever a valid is presented.
  always @(negedge clk) begin
    logic [8:0] e;
    if (mon_en) begin
      if (valid_a) begin
        if (qa.size() == 0) begin
          chk("spurious_valid_a", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("q_a", q_a, e[7:0]);
          chk("uninit_a", uninit_a, e[8]);
          last_qa = e[7:0];
        end
      end else begin
        chk("missing_valid_a", qa.size(), 0);
        chk("q_a_hold", q_a, last_qa);
        chk("uninit_a_idle", uninit_a, 0);
      end
      if (valid_b) begin
        if (qb.size() == 0) begin
          chk("spurious_valid_b", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("q_b", q_b, e[7:0]);
          chk("uninit_b", uninit_b, e[8]);
          last_qb = e[7:0];
        end
      end else begin
        chk("missing_valid_b", qb.size(), 0);
        chk("q_b_hold", q_b, last_qb);
        chk("uninit_b_idle", uninit_b, 0);
      end
      chk("collision", collision, exp_col);
      chk("col_count", col_count, exp_cnt);
    end
  end

  initial begin
    // reset with junk requests that must be discarded
    cyc(1'b0, 1'b1, 1'b1, 6'd4, 8'h99, 1'b1, 1'b0, 6'd4, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 6'd4, 8'h00, 1'b1, 1'b1, 6'd7, 8'h77);
    // first request after reset: read of never-written entry
    cyc(1'b1, 1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd4, 8'h00);
    idle();
    // basic write/read on both ports
    cyc(1'b1, 1'b1, 1'b1, 6'd0, 8'h0A, 1'b1, 1'b1, 6'd1, 8'hBB);
    cyc(1'b1, 1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd1, 8'h00);
    // read-first on same-address read/write
    cyc(1'b1, 1'b1, 1'b1, 6'd2, 8'h11, 1'b0, 1'b0, 6'd0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 6'd2, 8'h00, 1'b1, 1'b1, 6'd2, 8'h22);
    cyc(1'b1, 1'b1, 1'b0, 6'd2, 8'h00, 1'b1, 1'b0, 6'd2, 8'h00);
    // write collision, then read back
    cyc(1'b1, 1'b1, 1'b1, 6'd3, 8'hAA, 1'b1, 1'b1, 6'd3, 8'h55);
    idle();
    cyc(1'b1, 1'b1, 1'b0, 6'd3, 8'h00, 1'b1, 1'b0, 6'd3, 8'h00);
    // ignored fields with req low
    cyc(1'b1, 1'b0, 1'b1, 6'd3, 8'hEE, 1'b0, 1'b1, 6'd3, 8'hEE);
    cyc(1'b1, 1'b1, 1'b0, 6'd3, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    // saturating collision counter
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 6'(i % 64), 8'($urandom), 1'b1, 1'b1, 6'(i % 64), 8'($urandom));
    end
    idle();
    // read, then reset next cycle, then read the previously written address
    cyc(1'b1, 1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd1, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 6'd1, 8'h33);
    cyc(1'b1, 1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd1, 8'h00);
    idle();
    // random traffic on a narrow address window to provoke conflicts
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 59) != 0),
          1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom),
          1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom));
    end
    idle();
    idle();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memoria_dp.md
MEMORIA_DP -- requirements
Module: memoria_dp

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each memory word and each data port.
REQ-002 Parameter ADDR_WIDTH, default 6: address width; depth is 2**ADDR_WIDTH entries (64 by default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_L  input  1  reset, synchronous and active-low.
REQ-005 req_a  input  1  port A access request, valid this cycle.
REQ-006 we_a  input  1  port A write enable; 1 = write, 0 = read (only when req_a=1).
REQ-007 addr_a  input  ADDR_WIDTH  port A address.
REQ-008 data_a  input  DATA_WIDTH  port A write data.
REQ-009 req_b, we_b, addr_b, data_b  input  1/1/ADDR_WIDTH/DATA_WIDTH  port B, same meaning as port A.
REQ-010 q_a, q_b  output  DATA_WIDTH  registered read data per port.
REQ-011 valid_a, valid_b  output  1  q_x holds the result of a read issued one cycle earlier.
REQ-012 uninit_a, uninit_b  output  1  the read returned by q_x hit an entry never written since reset.
REQ-013 collision  output  1  one-cycle pulse: both ports wrote the same address in the previous cycle.
REQ-014 col_count  output  8  saturating count of write collisions since reset.

Function
REQ-015 A write (req_x=1, we_x=1) shall store data_x at addr_x at the clock edge and set that entry's written bit.
REQ-016 A read (req_x=1, we_x=0) shall present mem[addr_x] on q_x with valid_x=1 exactly one cycle later (latency 1).
REQ-017 valid_x shall be 0 in any cycle following a cycle with req_x=0 or we_x=1; q_x shall then hold its last value.
REQ-018 uninit_x shall equal the complement of the entry's written bit sampled with the read, and shall be 0 whenever valid_x=0.
REQ-019 Read on one port and write on the other port to the same address in the same cycle: the read shall return the old (pre-write) data and old written bit (read-first).
REQ-020 Both ports writing the same address in the same cycle: port A data shall be stored, port B data discarded, collision=1 in the next cycle.
REQ-021 Both ports writing different addresses, or both reading any addresses (including the same), shall complete independently with no collision.
REQ-022 collision shall be a single-cycle pulse per colliding cycle; back-to-back colliding cycles shall give back-to-back pulses.
REQ-023 col_count shall increment by 1 per collision and hold at 255 (no wrap).
REQ-024 we_x, addr_x and data_x shall be ignored when req_x=0.

Reset
REQ-025 With reset_L=0 at a clock edge: q_a=q_b=0, valid_a=valid_b=0, uninit_a=uninit_b=0, collision=0, col_count=0, all written bits=0, all memory entries=0.
REQ-026 Requests sampled during a reset cycle shall be discarded; no write takes effect and no valid is produced in the following cycle.
REQ-027 Reset asserted one cycle after a read shall win: valid_x=0 and q_x=0 after that edge.
REQ-028 The first request after reset_L returns to 1 shall be serviced normally.

Verification
REQ-029 Write A: addr 0 <- 0x0A, B: addr 1 <- 0xBB; then read A addr 0, B addr 1 -> next cycle q_a=0x0A, q_b=0xBB, valid_a=valid_b=1, uninit=0, collision=0.
REQ-030 Read A addr 5 right after reset -> q_a=0x00, valid_a=1, uninit_a=1.
REQ-031 Addr 2 holds 0x11; A reads 2 while B writes 0x22 to 2 -> q_a=0x11; read again next -> q_a=0x22.
REQ-032 A writes 0xAA and B writes 0x55 to addr 3 in one cycle -> collision=1 for one cycle, col_count=1, later read of 3 returns 0xAA.
REQ-033 300 consecutive colliding cycles -> col_count stops at 255, collision=1 on each following cycle.
REQ-034 Issue a read, assert reset_L=0 next cycle, then read previously written addr -> valid_x=0 during reset, read returns 0x00 with uninit_x=1.
